fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default memory_pkg::MEM_ADDR_WIDTH, instruction-memory byte-address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 first_fetch_trigger  input  1  one-cycle start pulse, leaves IDLE.
REQ-006 imem_rd_en  output  1  read strobe to instruction memory.
REQ-007 imem_addr  output  ADDR_W  read byte address, pc[ADDR_W-1:0].
REQ-008 imem_rdata  input  32  read data, valid exactly one cycle after imem_rd_en.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 inst_valid  output  1  instruction available to decode.
REQ-012 inst_ready  input  1  decode accepts instruction.
REQ-013 inst_data  output  32  instruction word at FIFO head.
REQ-014 inst_pc  output  32  PC of inst_data.
REQ-015 misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Function
REQ-016 FSM states: IDLE (no fetch) and RUN; IDLE->RUN on first_fetch_trigger; RUN has no exit except rst.
REQ-017 first_fetch_trigger in RUN is ignored.
REQ-018 Internal 2-entry FIFO of {pc, instr}; occupancy = FIFO count + in-flight reads, never above 2.
REQ-019 Pop = inst_valid & inst_ready; inst_valid = FIFO not empty; inst_data/inst_pc = head entry.
REQ-020 Issue (imem_rd_en=1) in RUN when occupancy - pop < 2 and no redirect this cycle; at most one read per cycle.
REQ-021 On issue, pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0).
REQ-022 Response captured into FIFO tail the cycle after issue, tagged with the issue PC.
REQ-023 Latency: trigger at cycle T -> imem_rd_en=1, imem_addr=RESET_PC at T+1 -> inst_valid=1 at T+2.
REQ-024 Throughput: inst_ready held high -> one instruction per cycle, no bubbles.
REQ-025 Redirect in RUN: FIFO flushed, an in-flight read is killed (its rdata next cycle discarded), pc <= {redirect_pc[31:2],2'b00}, no issue that cycle; first read of new PC next cycle.
REQ-026 Redirect and pop in the same cycle: pop completes, then flush; inst_valid=0 the following cycle.
REQ-027 Redirect in IDLE: pc updated, state stays IDLE, no read issued.
REQ-028 misalign_err pulses the cycle after a redirect with redirect_pc[1:0] != 0; the fetch proceeds at the word-aligned address.
REQ-029 FIFO full and inst_ready=0: no issue, head held stable (inst_data/inst_pc unchanged) until popped.

Reset
REQ-030 rst asserted: state=IDLE, pc=RESET_PC, FIFO empty, in-flight cleared, immediately and independent of clk.
REQ-031 Outputs under reset: imem_rd_en=0, inst_valid=0, misalign_err=0, imem_addr=RESET_PC[ADDR_W-1:0], inst_data=0, inst_pc=0.
REQ-032 rst mid-operation discards FIFO contents and any in-flight response; the next fetch requires a new first_fetch_trigger.

Structure
REQ-033 memory_pkg holds FETCH_FIFO_DEPTH (=2), the fetch-entry typedef {pc, instr} and the RESET_PC default constant.
REQ-034 FIFO implemented as sub-module fetch_fifo (depth 2, flush input); FSM, PC and issue logic live in fetch_unit.

Verification
REQ-035 rst, trigger at T, inst_ready=1 -> imem_addr 0x0,0x4,0x8 at T+1..T+3; inst_pc 0x0,0x4,0x8 at T+2..T+4 with matching inst_data.
REQ-036 Run then inst_ready=0 for 5 cycles -> exactly 2 entries buffered, imem_rd_en=0 while full, no entry lost or duplicated after inst_ready=1.
REQ-037 Redirect to 0x100 while read of 0x8 in flight -> 0x8 data never presented; next inst_pc=0x100, two cycles after the redirect cycle.
REQ-038 Redirect to 0x102 -> misalign_err one-cycle pulse, fetch from 0x100.
REQ-039 pc=0xFFFF_FFFC -> next fetch at 0x0000_0000.
REQ-040 rst asserted mid-stream with FIFO full -> inst_valid=0 and imem_rd_en=0 asynchronously; no fetch until new trigger, which restarts at RESET_PC.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared fetch-path types and constants: FIFO depth, address width, reset PC, fetch entry layout.
// Imported by the fetch unit and its FIFO.
package memory_pkg;

    localparam int          MEM_ADDR_WIDTH   = 32;
    localparam int          FETCH_FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a flush input.
// Head is registered (no fall-through); push while full is accepted only alongside a pop.
module fetch_fifo
    import memory_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_dat_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop_i && (cnt_q != '0);
        do_push  = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        // Flush wins over everything, including a same-cycle pop.
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;
    assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE/RUN FSM, PC, one read per cycle into a 2-deep buffer; first instruction
// two cycles after trigger (response bypasses the buffer), stalls issue when buffer + in-flight reach 2.
module fetch_unit
    import memory_pkg::*;
#(
    parameter int          ADDR_W   = MEM_ADDR_WIDTH,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              first_fetch_trigger,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    output logic              misalign_err
);

    localparam int CNT_W = $clog2(FETCH_FIFO_DEPTH + 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         misalign_q, misalign_d;

    fetch_entry_t     fifo_head;
    fetch_entry_t     rsp_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             rsp_vld;
    logic             pop;
    logic             issue;
    logic [2:0]       occ_after_pop;

    assign rsp_entry = '{pc: inflight_pc_q, instr: imem_rdata};

    // Datapath around the buffer: a landing response is presented directly when the buffer is
    // empty, and is dropped outright if a redirect arrives in the same cycle.
    always_comb begin
        rsp_vld       = inflight_q && !redirect_valid;
        inst_valid    = !fifo_empty || rsp_vld;
        head          = fifo_empty ? rsp_entry : fifo_head;
        pop           = inst_valid && inst_ready;
        fifo_pop      = pop && !fifo_empty;
        fifo_push     = rsp_vld && !(fifo_empty && pop);
        occ_after_pop = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);
        issue         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (first_fetch_trigger) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = !redirect_valid && (occ_after_pop < 3'd2);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FETCH_FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_i     (fifo_push),
        .push_dat_i (rsp_entry),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    assign imem_rd_en   = issue;
    assign imem_addr    = pc_q[ADDR_W-1:0];
    assign inst_data    = inst_valid ? head.instr : 32'h0;
    assign inst_pc      = inst_valid ? head.pc : 32'h0;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-accurate vector table plus an in-order scoreboard of delivered
// instructions, followed by hand-written reset and idle-redirect sequences.
module tb_fetch_unit;
    import memory_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] rdata = 32'h0;
    logic        rv;
    logic [31:0] rpc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .first_fetch_trigger (trig),
        .imem_rd_en          (rd_en),
        .imem_addr           (addr),
        .imem_rdata          (rdata),
        .redirect_valid      (rv),
        .redirect_pc         (rpc),
        .inst_valid          (inst_valid),
        .inst_ready          (inst_ready),
        .inst_data           (inst_data),
        .inst_pc             (inst_pc),
        .misalign_err        (misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous instruction memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rdata <= mem_word(addr);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted instruction must be the next expected PC with its memory word.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %h expected no delivery", inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check32("sb_pc", inst_pc, e);
                check32("sb_data", inst_data, mem_word(e));
            end
        end
    end

    typedef struct {
        logic        trig;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] sb_base;
        int          sb_n;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    localparam int NV = 26;
    vec_t v[NV];

    function automatic vec_t mk(input logic t, input logic r, input logic redir,
                                input logic [31:0] rp, input logic [31:0] base, input int n,
                                input logic erd, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic em);
        vec_t x;
        x.trig = t;  x.rdy = r;  x.rv = redir;  x.rpc = rp;
        x.sb_base = base;  x.sb_n = n;
        x.e_rd = erd;  x.e_addr = ea;  x.e_vld = ev;  x.e_pc = ep;  x.e_mis = em;
        return x;
    endfunction

    initial begin
        //          trig  rdy   rv    rpc            sb_base        n  rd_en addr           vld   pc             mis
        v[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         6, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0);
        v[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0);
        v[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h4,         1'b1, 32'h0,         1'b0);
        v[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h8,         1'b1, 32'h4,         1'b0);
        v[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'hC,         1'b1, 32'h8,         1'b0);
        v[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0, 32'h10,        1'b1, 32'h8,         1'b0);
        v[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0, 32'h10,        1'b1, 32'h8,         1'b0);
        v[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0, 32'h10,        1'b1, 32'h8,         1'b0);
        v[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0, 32'h10,        1'b1, 32'h8,         1'b0);
        v[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h10,        1'b1, 32'h8,         1'b0);
        v[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h14,        1'b1, 32'hC,         1'b0);
        v[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h18,        1'b1, 32'h10,        1'b0);
        v[12] = mk(1'b0, 1'b1, 1'b1, 32'h100,       32'h100,       1, 1'b0, 32'h1C,        1'b1, 32'h14,        1'b0);
        v[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0);
        v[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h104,       1'b1, 32'h100,       1'b0);
        v[15] = mk(1'b0, 1'b1, 1'b1, 32'h202,       32'h200,       1, 1'b0, 32'h108,       1'b0, 32'h0,         1'b0);
        v[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1);
        v[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h204,       1'b1, 32'h200,       1'b0);
        v[18] = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 3, 1'b0, 32'h208,       1'b0, 32'h0,         1'b0);
        v[19] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         1'b0);
        v[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 1'b0);
        v[21] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0);
        v[22] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h4,         1'b1, 32'h0,         1'b0);
        v[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h8,         1'b1, 32'h4,         1'b0);
        v[24] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0, 32'hC,         1'b1, 32'h4,         1'b0);
        v[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1'b0, 32'hC,         1'b1, 32'h4,         1'b0);

        rst = 1'b1;  trig = 1'b0;  rv = 1'b0;  rpc = 32'h0;  inst_ready = 1'b0;
        #12;
        check1 ("rst rd_en",    rd_en,      1'b0);
        check1 ("rst valid",    inst_valid, 1'b0);
        check1 ("rst misalign", misalign,   1'b0);
        check32("rst addr",     addr,       32'h0);
        check32("rst data",     inst_data,  32'h0);
        check32("rst pc",       inst_pc,    32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            trig       = v[i].trig;
            inst_ready = v[i].rdy;
            rv         = v[i].rv;
            rpc        = v[i].rpc;
            for (int k = 0; k < v[i].sb_n; k++) exp_q.push_back(v[i].sb_base + 32'(4 * k));
            @(negedge clk);
            check1 ($sformatf("c%0d rd_en", i),    rd_en,      v[i].e_rd);
            check32($sformatf("c%0d addr", i),     addr,       v[i].e_addr);
            check1 ($sformatf("c%0d valid", i),    inst_valid, v[i].e_vld);
            check1 ($sformatf("c%0d misalign", i), misalign,   v[i].e_mis);
            if (v[i].e_vld) check32($sformatf("c%0d inst_pc", i), inst_pc, v[i].e_pc);
            @(posedge clk); #1;
        end
        trig = 1'b0;  rv = 1'b0;
        check32("sb_drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset with the buffer full: outputs must drop before any clock edge.
        #2 rst = 1'b1;
        #1;
        check1 ("arst valid",    inst_valid, 1'b0);
        check1 ("arst rd_en",    rd_en,      1'b0);
        check32("arst addr",     addr,       32'h0);
        check32("arst data",     inst_data,  32'h0);
        check32("arst pc",       inst_pc,    32'h0);
        check1 ("arst misalign", misalign,   1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1($sformatf("idle%0d rd_en", i), rd_en,      1'b0);
            check1($sformatf("idle%0d valid", i), inst_valid, 1'b0);
            @(posedge clk); #1;
        end
        trig = 1'b1;
        @(negedge clk);
        check1("retrig rd_en0", rd_en, 1'b0);
        @(posedge clk); #1;
        trig = 1'b0;
        @(negedge clk);
        check1 ("retrig rd_en1", rd_en, 1'b1);
        check32("retrig addr",   addr,  32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check1 ("retrig valid", inst_valid, 1'b1);
        check32("retrig pc",    inst_pc,    32'h0);
        check32("retrig data",  inst_data,  mem_word(32'h0));

        // Redirect while idle: PC moves, no read, misalign pulse, trigger starts at the new PC.
        @(posedge clk); #1;
        rst = 1'b1;
        #1 rst = 1'b0;
        rv = 1'b1;  rpc = 32'h0000_0041;
        @(negedge clk);
        check1("idle_rd rd_en0", rd_en, 1'b0);
        @(posedge clk); #1;
        rv = 1'b0;
        @(negedge clk);
        check1 ("idle_rd rd_en1",    rd_en,    1'b0);
        check1 ("idle_rd misalign1", misalign, 1'b1);
        check32("idle_rd addr",      addr,     32'h40);
        @(posedge clk); #1;
        trig = 1'b1;
        @(negedge clk);
        check1("idle_rd misalign0", misalign, 1'b0);
        check1("idle_rd rd_en2",    rd_en,    1'b0);
        @(posedge clk); #1;
        trig = 1'b0;
        @(negedge clk);
        check1 ("idle_rd rd_en3", rd_en, 1'b1);
        check32("idle_rd first",  addr,  32'h40);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
